// File: rtl/prime_tester.sv
// prime_tester: trial-division primality controller driving an external divmod unit.
// The sqrt bound comes from the divmod quotient, so no multiplier is needed.
module prime_tester #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             is_prime,
    output logic [WIDTH-1:0] factor,
    output logic             error,
    output logic             dm_go,
    output logic [WIDTH-1:0] dm_a,
    output logic [WIDTH-1:0] dm_b,
    input  logic             dm_ready,
    input  logic             dm_error,
    input  logic [WIDTH-1:0] dm_div,
    input  logic [WIDTH-1:0] dm_mod
);
    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, WAIT} state_t;
    state_t state;
    logic   guard;
    // dm_b doubles as the current trial divisor d
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            guard    <= 1'b0;
            ready    <= 1'b1;
            is_prime <= 1'b0;
            factor   <= '0;
            error    <= 1'b0;
            dm_go    <= 1'b0;
            dm_a     <= '0;
            dm_b     <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    dm_a     <= n;
                    is_prime <= 1'b0;
                    factor   <= '0;
                    error    <= 1'b0;
                    ready    <= 1'b0;
                    state    <= CHECK;
                end
                CHECK: if (dm_a < WIDTH'(2)) begin
                    ready <= 1'b1;
                    state <= IDLE;
                end else if (dm_a < WIDTH'(4)) begin
                    is_prime <= 1'b1;
                    factor   <= dm_a;
                    ready    <= 1'b1;
                    state    <= IDLE;
                end else begin
                    dm_b  <= WIDTH'(2);
                    dm_go <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    dm_go <= 1'b0;
                    guard <= 1'b1;
                    state <= WAIT;
                end
                // the guard cycle skips a dm_ready left over from the previous division
                WAIT: if (guard) begin
                    guard <= 1'b0;
                end else if (dm_ready) begin
                    if (dm_error) begin
                        error <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else if (dm_mod == '0) begin
                        factor <= dm_b;
                        ready  <= 1'b1;
                        state  <= IDLE;
                    end else if (dm_div <= dm_b) begin
                        is_prime <= 1'b1;
                        factor   <= dm_a;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        dm_b  <= dm_b + WIDTH'(1);
                        dm_go <= 1'b1;
                        state <= ISSUE;
                    end
                end
            endcase
        end
    end
endmodule
